sw_cfg_slave: RTL and testbench

- Per-switch configuration register target. One instance per switch, sitting directly downstream of the address decoder.
- Consumes that switch's sel_en bit plus the shared wr_rd_s, addr and wr_data lines. Performs the register write or read.
- Returns a one-cycle ack and, for reads, rd_data. rd_data is zero-gated so all instances can be OR-combined onto the decoder's shared rd_data input.
- Exposes register contents to the switch datapath.

---
 rtl/sw_cfg_if.sv | 23 ++
 rtl/sw_cfg_slave.sv | 156 +++++++++++++++
 tb/tb_sw_cfg_slave.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_cfg_if.sv
// Request/response bundle between the address decoder and one switch's config slave.
interface sw_cfg_if #(
  parameter int W_WIDTH = 8
);
  logic               sel_en;
  logic               wr_rd_s;
  logic [W_WIDTH-1:0] addr;
  logic [W_WIDTH-1:0] wr_data;
  logic               ack;
  logic [W_WIDTH-1:0] rd_data;
  logic               busy;
  logic               err;

  modport master (
    output sel_en, wr_rd_s, addr, wr_data,
    input  ack, rd_data, busy, err
  );

  modport slave (
    input  sel_en, wr_rd_s, addr, wr_data,
    output ack, rd_data, busy, err
  );
endinterface

// File: rtl/sw_cfg_slave.sv
// Per-switch configuration register target: register writes/reads with a one-cycle ack,
// zero-gated rd_data for wired-OR combining, and register contents exported to the datapath.
module sw_cfg_slave #(
  parameter int                 W_WIDTH    = 8,
  parameter int                 NUM_REGS   = 4,
  parameter int                 READ_DELAY = 1,
  parameter logic [W_WIDTH-1:0] SW_ID      = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sw_cfg_if.slave                     bus,
  output logic [NUM_REGS*W_WIDTH-1:0] reg_out
);

  localparam int CNT_W = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WR_ACK,
    RD_WAIT,
    RD_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [W_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [W_WIDTH-1:0] snap_q, snap_d;
  logic               snap_err_q, snap_err_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [W_WIDTH-1:0] rd_data_q, rd_data_d;

  logic               addr_in_range;
  logic               addr_is_reg;
  logic [W_WIDTH-1:0] rd_val;

  // Address decode and read mux, evaluated against the request on the bus this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    addr_in_range = (32'(bus.addr) < NUM_REGS);
    addr_is_reg   = addr_in_range && (bus.addr != '0);
    rd_val        = (bus.addr == '0) ? SW_ID : '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (32'(bus.addr) == k) rd_val = regs_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    regs_d     = regs_q;
    snap_d     = snap_q;
    snap_err_d = snap_err_q;
    ack_d      = 1'b0;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.sel_en) begin
          busy_d = 1'b1;
          if (bus.wr_rd_s) begin
            for (int k = 1; k < NUM_REGS; k++) begin
              if (addr_is_reg && (32'(bus.addr) == k)) regs_d[k] = bus.wr_data;
            end
            state_d = WR_ACK;
            ack_d   = 1'b1;
            err_d   = !addr_is_reg;
          end else begin
            // Snapshot now so the returned value is the one present at the accept edge.
            snap_d     = rd_val;
            snap_err_d = !addr_in_range;
            if (READ_DELAY == 1) begin
              state_d   = RD_ACK;
              ack_d     = 1'b1;
              rd_data_d = rd_val;
              err_d     = !addr_in_range;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = CNT_W'(READ_DELAY - 1);
            end
          end
        end
      end

      // A select seen in any non-IDLE state is dropped and flagged one cycle later.
      WR_ACK: begin
        state_d = IDLE;
        err_d   = bus.sel_en;
      end

      RD_WAIT: begin
        busy_d = 1'b1;
        err_d  = bus.sel_en;
        if (cnt_q == CNT_W'(1)) begin
          state_d   = RD_ACK;
          ack_d     = 1'b1;
          rd_data_d = snap_q;
          err_d     = bus.sel_en | snap_err_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RD_ACK: begin
        state_d = IDLE;
        err_d   = bus.sel_en;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      snap_err_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      // NOTE: the register file is architecturally visible on reg_out, so it is reset like any other state.
      for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      snap_err_q <= snap_err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    reg_out                = '0;
    reg_out[W_WIDTH-1:0]   = SW_ID;
    for (int k = 1; k < NUM_REGS; k++) begin
      reg_out[k*W_WIDTH +: W_WIDTH] = regs_q[k];
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_sw_cfg_slave.sv
// Self-checking bench for sw_cfg_slave: directed scenarios plus randomized traffic
// compared against a register-array reference model.
module tb_sw_cfg_slave;
  localparam int         W  = 8;
  localparam int         N  = 4;
  localparam int         RD = 3;
  localparam logic [7:0] ID = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N*W-1:0]   reg_out;

  sw_cfg_if #(.W_WIDTH(W)) bus ();

  sw_cfg_slave #(
    .W_WIDTH   (W),
    .NUM_REGS  (N),
    .READ_DELAY(RD),
    .SW_ID     (ID)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mdl [N];

  // What the last transaction looked like, cycle by cycle after the accept edge.
  int          o_ack_cyc;
  int          o_n_ack;
  logic [7:0]  o_rd;
  logic        o_err;
  logic [8:0]  o_busy;
  logic [8:0]  o_err_mask;
  logic        o_leak;
  logic [31:0] o_ro1;
  logic [31:0] o_ro_end;

  function automatic logic [31:0] mdl_regout();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  // Issue one request, optionally re-pulse sel_en in cycle rp, observe ncyc cycles.
  task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input int rp, input int ncyc);
    o_ack_cyc = 0; o_n_ack = 0; o_rd = '0; o_err = 1'b0;
    o_busy = '0; o_err_mask = '0; o_leak = 1'b0; o_ro1 = '0; o_ro_end = '0;
    @(negedge clk);
    bus.sel_en = 1'b1; bus.wr_rd_s = wr; bus.addr = a; bus.wr_data = d;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) o_ro1 = reg_out;
      o_ro_end  = reg_out;
      o_busy[c] = bus.busy;
      if (bus.ack) begin
        o_n_ack++;
        if (o_ack_cyc == 0) begin
          o_ack_cyc = c; o_rd = bus.rd_data; o_err = bus.err;
        end
      end else begin
        if (bus.rd_data !== 8'h00) o_leak = 1'b1;
        if (bus.err) o_err_mask[c] = 1'b1;
      end
      if (c == rp) begin
        bus.sel_en = 1'b1; bus.wr_rd_s = 1'($urandom);
        bus.addr = 8'($urandom_range(0, 3)); bus.wr_data = 8'($urandom);
      end else begin
        bus.sel_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b busy=%b err=%b rd_data=%h, required 0 0 0 00",
               bus.ack, bus.busy, bus.err, bus.rd_data);
    end
    rst_n = 1'b1;
    mdl[0] = ID; mdl[1] = 8'h00; mdl[2] = 8'h00; mdl[3] = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 ||
          bus.rd_data !== 8'h00 || reg_out !== 32'h000000A5) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: ack=%b busy=%b err=%b rd_data=%h reg_out=%h, required 0 0 0 00 000000a5",
                 i, bus.ack, bus.busy, bus.err, bus.rd_data, reg_out);
      end
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 8'd2, 8'h3C, 0, 8);
    mdl[2] = 8'h3C;
    n_tests++;
    if (o_ack_cyc !== 1 || o_n_ack !== 1) begin
      n_fail++; $display("FAIL write_ack: cycle=%0d count=%0d, required cycle 1 count 1", o_ack_cyc, o_n_ack);
    end
    n_tests++;
    if (o_busy !== 9'b000000010) begin
      n_fail++; $display("FAIL write_busy: mask=%b, required 000000010", o_busy);
    end
    n_tests++;
    if (o_ro1 !== 32'h003C00A5) begin
      n_fail++; $display("FAIL write_reg_out: got %h, required 003c00a5", o_ro1);
    end
    n_tests++;
    if (o_err !== 1'b0 || o_err_mask !== 9'd0 || o_rd !== 8'h00 || o_leak !== 1'b0) begin
      n_fail++;
      $display("FAIL write_err_rd: err=%b err_mask=%b rd=%h leak=%b, required 0 0 00 0", o_err, o_err_mask, o_rd, o_leak);
    end
  endtask

  task automatic test_read();
    run_txn(1'b0, 8'd2, 8'h00, 0, 8);
    n_tests++;
    if (o_ack_cyc !== 3 || o_n_ack !== 1 || o_rd !== 8'h3C || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_reg2: ack_cycle=%0d count=%0d rd=%h err=%b, required 3 1 3c 0", o_ack_cyc, o_n_ack, o_rd, o_err);
    end
    n_tests++;
    if (o_busy !== 9'b000001110 || o_leak !== 1'b0) begin
      n_fail++; $display("FAIL read_busy: mask=%b leak=%b, required 000001110 0", o_busy, o_leak);
    end
    run_txn(1'b0, 8'd0, 8'h00, 0, 8);
    n_tests++;
    if (o_ack_cyc !== 3 || o_rd !== 8'hA5 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL read_id: ack_cycle=%0d rd=%h err=%b, required 3 a5 0", o_ack_cyc, o_rd, o_err);
    end
  endtask

  task automatic test_out_of_range();
    run_txn(1'b1, 8'd0, 8'h5A, 0, 8);
    n_tests++;
    if (o_ack_cyc !== 1 || o_err !== 1'b1 || o_ro_end !== 32'h003C00A5) begin
      n_fail++;
      $display("FAIL write_addr0: ack_cycle=%0d err=%b reg_out=%h, required 1 1 003c00a5", o_ack_cyc, o_err, o_ro_end);
    end
    run_txn(1'b1, 8'd7, 8'hFF, 0, 8);
    n_tests++;
    if (o_ack_cyc !== 1 || o_err !== 1'b1 || o_ro_end !== 32'h003C00A5) begin
      n_fail++;
      $display("FAIL write_addr7: ack_cycle=%0d err=%b reg_out=%h, required 1 1 003c00a5", o_ack_cyc, o_err, o_ro_end);
    end
    run_txn(1'b0, 8'd7, 8'h00, 0, 8);
    n_tests++;
    if (o_ack_cyc !== 3 || o_rd !== 8'h00 || o_err !== 1'b1 || o_n_ack !== 1) begin
      n_fail++;
      $display("FAIL read_addr7: ack_cycle=%0d rd=%h err=%b count=%0d, required 3 00 1 1", o_ack_cyc, o_rd, o_err, o_n_ack);
    end
  endtask

  task automatic test_drop();
    run_txn(1'b0, 8'd2, 8'h00, 1, 8);
    n_tests++;
    if (o_err_mask !== 9'b000000100) begin
      n_fail++; $display("FAIL drop_err: mask=%b, required 000000100", o_err_mask);
    end
    n_tests++;
    if (o_ack_cyc !== 3 || o_n_ack !== 1 || o_rd !== 8'h3C || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ack: ack_cycle=%0d count=%0d rd=%h err=%b, required 3 1 3c 0", o_ack_cyc, o_n_ack, o_rd, o_err);
    end
    n_tests++;
    if (o_ro_end !== 32'h003C00A5) begin
      n_fail++; $display("FAIL drop_regs: reg_out=%h, required 003c00a5", o_ro_end);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 8'd1, 8'h77, 0, 1);
    run_txn(1'b0, 8'd1, 8'h00, 0, RD);
    mdl[1] = 8'h77;
    n_tests++;
    if (o_ack_cyc !== RD || o_rd !== 8'h77) begin
      n_fail++; $display("FAIL b2b_read1: ack_cycle=%0d rd=%h, required %0d 77", o_ack_cyc, o_rd, RD);
    end
    run_txn(1'b1, 8'd3, 8'hC3, 0, 1);
    mdl[3] = 8'hC3;
    n_tests++;
    if (o_ack_cyc !== 1 || o_ro1 !== 32'hC33C77A5) begin
      n_fail++; $display("FAIL b2b_write3: ack_cycle=%0d reg_out=%h, required 1 c33c77a5", o_ack_cyc, o_ro1);
    end
    run_txn(1'b0, 8'd3, 8'h00, 0, RD);
    n_tests++;
    if (o_ack_cyc !== RD || o_rd !== 8'hC3) begin
      n_fail++; $display("FAIL b2b_read3: ack_cycle=%0d rd=%h, required %0d c3", o_ack_cyc, o_rd, RD);
    end
  endtask

  task automatic test_reset_abort();
    int acks;
    acks = 0;
    @(negedge clk);
    bus.sel_en = 1'b1; bus.wr_rd_s = 1'b0; bus.addr = 8'd3; bus.wr_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    bus.sel_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ack !== 1'b0 || reg_out !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL abort_immediate: busy=%b ack=%b reg_out=%h, required 0 0 000000a5", bus.busy, bus.ack, reg_out);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack) acks++;
      if (i == 2) rst_n = 1'b1;
    end
    mdl[1] = 8'h00; mdl[2] = 8'h00; mdl[3] = 8'h00;
    n_tests++;
    if (acks !== 0) begin
      n_fail++; $display("FAIL abort_no_ack: acks=%0d, required 0", acks);
    end
    run_txn(1'b1, 8'd3, 8'h5E, 0, 4);
    mdl[3] = 8'h5E;
    n_tests++;
    if (o_ack_cyc !== 1 || o_err !== 1'b0 || o_ro1 !== 32'h5E0000A5) begin
      n_fail++;
      $display("FAIL abort_recover: ack_cycle=%0d err=%b reg_out=%h, required 1 0 5e0000a5", o_ack_cyc, o_err, o_ro1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
      int         lat;
      int         rp;
      logic       e_err;
      logic [7:0] e_rd;
      logic [8:0] e_em;
      logic [8:0] e_busy;
      wr  = 1'($urandom);
      a   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      d   = 8'($urandom);
      lat = wr ? 1 : RD;
      rp  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat)) : 0;
      e_rd  = (!wr && a < N) ? mdl[a[1:0]] : 8'h00;
      e_err = wr ? (a == 8'd0 || a >= N) : (a >= N);
      e_busy = '0;
      for (int c = 1; c <= lat; c++) e_busy[c] = 1'b1;
      e_em = '0;
      if (rp != 0) begin
        if (rp + 1 == lat) e_err = 1'b1;
        else e_em[rp+1] = 1'b1;
      end
      if (wr && a != 8'd0 && a < N) mdl[a[1:0]] = d;
      run_txn(wr, a, d, rp, lat + 1);
      n_tests++;
      if (o_ack_cyc !== lat || o_n_ack !== 1) begin
        n_fail++;
        $display("FAIL rand%0d_ack: wr=%b addr=%h cycle=%0d count=%0d, required %0d 1", i, wr, a, o_ack_cyc, o_n_ack, lat);
      end
      n_tests++;
      if (o_rd !== e_rd || o_leak !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_rd: wr=%b addr=%h rd=%h leak=%b, required %h 0", i, wr, a, o_rd, o_leak, e_rd);
      end
      n_tests++;
      if (o_err !== e_err || o_err_mask !== e_em) begin
        n_fail++;
        $display("FAIL rand%0d_err: wr=%b addr=%h rp=%0d err=%b mask=%b, required %b %b", i, wr, a, rp, o_err, o_err_mask, e_err, e_em);
      end
      n_tests++;
      if (o_busy !== e_busy) begin
        n_fail++; $display("FAIL rand%0d_busy: mask=%b, required %b", i, o_busy, e_busy);
      end
      n_tests++;
      if (o_ro_end !== mdl_regout()) begin
        n_fail++; $display("FAIL rand%0d_regs: reg_out=%h, required %h", i, o_ro_end, mdl_regout());
      end
    end
  endtask

  initial begin
    bus.sel_en = 1'b0; bus.wr_rd_s = 1'b0; bus.addr = '0; bus.wr_data = '0;
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_drop();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
